sync_fifo_flex: RTL and testbench
=================================

# sync_fifo_flex

Parametrised single-clock FIFO buffering PWM duty/period words between the host register interface and the PWM channel cores. It generalises the basic synchronous FIFO with arbitrary (non-power-of-two) depth, occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. A compile-time option selects first-word-fall-through read behaviour.

## Interface
- DEPTH, 8: number of entries; any integer ≥ 2.
- WIDTH, 8: data word width in bits; ≥ 1.
- AF_LEVEL, DEPTH-2: o_almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: o_almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.
- Derived constant CW = $clog2(DEPTH+1) for count width; PW = $clog2(DEPTH) for pointers.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_we  in  1  write request.
- i_re  in  1  read request.
- i_fifo  in  WIDTH  write data.
- i_clr_err  in  1  synchronous clear of sticky error flags.
- o_fifo  out  WIDTH  read data.
- o_valid  out  1  o_fifo holds valid read data.
- o_fifo_full  out  1  count == DEPTH.
- o_fifo_empty  out  1  count == 0.
- o_almost_full  out  1  count ≥ AF_LEVEL.
- o_almost_empty  out  1  count ≤ AE_LEVEL.
- o_count  out  CW  current occupancy.
- o_overflow  out  1  sticky: write attempted while full and not simultaneously read.
- o_underflow  out  1  sticky: read attempted while empty.

## Operation
- Reset (i_rst high, any time, mid-operation included): pointers and count 0, o_fifo 0, o_valid 0, o_fifo_full 0, o_fifo_empty 1, o_almost_full 0, o_almost_empty 1, o_overflow 0, o_underflow 0. Storage contents not cleared.
- Write accepted = i_we & (!full | read accepted). Read accepted = i_re & !empty.
- Full + i_we + i_re: both accepted, count unchanged, no overflow.
- Empty + i_we + i_re: write accepted, read rejected, o_underflow set.
- Full + i_we alone: write dropped, o_overflow set; data and pointers unchanged.
- Pointers increment on accept and wrap DEPTH-1 → 0 (explicit compare, not bit truncation).
- count += write accepted − read accepted; never outside 0..DEPTH.
- Error flags hold until i_clr_err or reset; if an error event and i_clr_err coincide, event wins (flag stays set).

## Timing
- All outputs registered; flags and o_count reflect state after the accepting edge, visible the same cycle as the updated pointers.
- Standard mode: o_fifo/o_valid update one cycle after a read accepted (o_valid pulses 1 cycle per accepted read; o_fifo holds last value otherwise).
- Write-to-read latency: entry written at edge N readable (read accepted) at edge N+1 earliest.
- Throughput: one write and one read per cycle sustained.

## Configuration
- Macro SYNC_FIFO_FWFT_EN defined: first-word-fall-through; o_fifo shows head entry and o_valid = !empty whenever non-empty, i_re acts as pop/acknowledge; head visible one cycle after first write into empty FIFO.
- Undefined: standard registered read as in Timing.
- Flag, count and error semantics identical in both modes.

## Structure
- Package sync_fifo_pkg: function clog2-based width helpers, default parameter constants (DEPTH, WIDTH, thresholds).
- Sub-module sync_fifo_mem: DEPTH×WIDTH storage, one write port, one registered/async read port selectable by top; top holds pointers, count, flags.

## Test plan
- Reset then write 0..7 (DEPTH=8): o_count 8, full 1, almost_full set at count 6, empty 0, no overflow.
- Read 8 words after fill: o_fifo sequence 0..7 with o_valid per read, empty 1 at end, almost_empty set at count 2.
- Write 9th word 8'hAA while full: dropped, o_overflow 1; pulse i_clr_err → 0; subsequent read returns 0.
- Simultaneous we/re at full and at empty: full stays 8 with data order preserved; empty case → count 1, o_underflow 1.
- DEPTH=5 wrap: write/read 12 words interleaved; output order matches input, pointers wrap at 4.
- Assert i_rst mid-fill at count 3 asynchronously: outputs immediately reset values; next write reads back correctly, both with and without SYNC_FIFO_FWFT_EN.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and width helpers for the flexible synchronous FIFO family.
package sync_fifo_pkg;

  localparam int DEF_DEPTH    = 8;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_AE_LEVEL = 2;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and one read port that is either
// registered (load on re, async-reset to zero) or combinational (REG_RD = 0).
module sync_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int PW     = 3,
  parameter bit REG_RD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (REG_RD) begin : g_reg_rd
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
      end
    end else begin : g_async_rd
      logic unused_rd;
      assign unused_rd = ^{re, rst};
      assign rdata = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, occupancy count, threshold and sticky
// error flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = DEF_AE_LEVEL,
  localparam int CW       = cnt_width(DEPTH),
  localparam int PW       = ptr_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [WIDTH-1:0] i_fifo,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_fifo,
  output logic             o_valid,
  output logic             o_fifo_full,
  output logic             o_fifo_empty,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [CW-1:0]    o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic          we_acc, re_acc;
  logic [WIDTH-1:0] mem_rdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    re_acc     = i_re & ~o_fifo_empty;
    we_acc     = i_we & (~o_fifo_full | re_acc);
    wr_ptr_nxt = we_acc ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_nxt = re_acc ? ptr_inc(rd_ptr) : rd_ptr;
    count_nxt  = o_count;
    if (we_acc && !re_acc)      count_nxt = o_count + 1'b1;
    else if (re_acc && !we_acc) count_nxt = o_count - 1'b1;
  end

  // Flags are derived from the post-edge count so they line up with o_count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_fifo_full    <= 1'b0;
      o_fifo_empty   <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      o_count        <= count_nxt;
      o_fifo_full    <= (count_nxt == CW'(DEPTH));
      o_fifo_empty   <= (count_nxt == '0);
      o_almost_full  <= (count_nxt >= CW'(AF_LEVEL));
      o_almost_empty <= (count_nxt <= CW'(AE_LEVEL));
      o_overflow     <= (i_we & o_fifo_full & ~re_acc) | (o_overflow & ~i_clr_err);
      o_underflow    <= (i_re & o_fifo_empty) | (o_underflow & ~i_clr_err);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic [WIDTH-1:0] head_nxt;

  sync_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PW(PW), .REG_RD(1'b0)) u_mem (
    .clk(i_clk), .rst(i_rst), .we(we_acc), .waddr(wr_ptr), .wdata(i_fifo),
    .re(re_acc), .raddr(rd_ptr_nxt), .rdata(mem_rdata)
  );

  // The next head may be the word being written this edge (write into empty slot).
  always_comb begin
    head_nxt = mem_rdata;
    if (we_acc && (wr_ptr == rd_ptr_nxt)) head_nxt = i_fifo;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fifo  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= (count_nxt != '0);
      if (count_nxt != '0) o_fifo <= head_nxt;
    end
  end
`else
  sync_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PW(PW), .REG_RD(1'b1)) u_mem (
    .clk(i_clk), .rst(i_rst), .we(we_acc), .waddr(wr_ptr), .wdata(i_fifo),
    .re(re_acc), .raddr(rd_ptr), .rdata(mem_rdata)
  );

  assign o_fifo = mem_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_valid <= 1'b0;
    else       o_valid <= re_acc;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a DEPTH=8 and a DEPTH=5 FIFO with identical stimulus and compares both
// against queue-based reference models.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst, we, re, clr;
  logic [7:0] din;

  logic [7:0] dout [2];
  logic       val [2], full [2], empty [2], af [2], ae [2], ovf [2], udf [2];
  logic [3:0] cnt0;
  logic [2:0] cnt1;

  int total = 0;
  int bad   = 0;

  int depth  [2] = '{8, 5};
  int af_lvl [2] = '{6, 4};
  int ae_lvl [2] = '{2, 1};

  logic [7:0] mq [2][$];
  logic [7:0] m_data [2];
  bit         m_valid [2], m_ovf [2], m_udf [2];

  always #5 clk = ~clk;

  sync_fifo_flex #(.DEPTH(8), .WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_re(re), .i_fifo(din), .i_clr_err(clr),
    .o_fifo(dout[0]), .o_valid(val[0]), .o_fifo_full(full[0]), .o_fifo_empty(empty[0]),
    .o_almost_full(af[0]), .o_almost_empty(ae[0]), .o_count(cnt0),
    .o_overflow(ovf[0]), .o_underflow(udf[0])
  );

  sync_fifo_flex #(.DEPTH(5), .WIDTH(8), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_re(re), .i_fifo(din), .i_clr_err(clr),
    .o_fifo(dout[1]), .o_valid(val[1]), .o_fifo_full(full[1]), .o_fifo_empty(empty[1]),
    .o_almost_full(af[1]), .o_almost_empty(ae[1]), .o_count(cnt1),
    .o_overflow(ovf[1]), .o_underflow(udf[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_data[k]  = '0;
      m_valid[k] = 1'b0;
      m_ovf[k]   = 1'b0;
      m_udf[k]   = 1'b0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int n;
      string p;
      n = mq[k].size();
      p = $sformatf("d%0d_", depth[k]);
      check({p, "count"}, (k == 0) ? 32'(cnt0) : 32'(cnt1), n);
      check({p, "full"},  full[k],  n == depth[k]);
      check({p, "empty"}, empty[k], n == 0);
      check({p, "afull"}, af[k],    n >= af_lvl[k]);
      check({p, "aempty"}, ae[k],   n <= ae_lvl[k]);
      check({p, "ovf"},   ovf[k],   m_ovf[k]);
      check({p, "udf"},   udf[k],   m_udf[k]);
      check({p, "valid"}, val[k],   m_valid[k]);
`ifdef SYNC_FIFO_FWFT_EN
      if (m_valid[k]) check({p, "data"}, dout[k], m_data[k]);
`else
      check({p, "data"}, dout[k], m_data[k]);
`endif
    end
  endtask

  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c);
    we = w; re = r; din = d; clr = c;
    for (int k = 0; k < 2; k++) begin
      int  n;
      bit  racc, wacc;
      n    = mq[k].size();
      racc = r && (n > 0);
      wacc = w && ((n < depth[k]) || racc);
      m_ovf[k] = (w && (n == depth[k]) && !racc) || (m_ovf[k] && !c);
      m_udf[k] = (r && (n == 0)) || (m_udf[k] && !c);
`ifndef SYNC_FIFO_FWFT_EN
      m_valid[k] = racc;
      if (racc) m_data[k] = mq[k][0];
`endif
      if (racc) void'(mq[k].pop_front());
      if (wacc) mq[k].push_back(d);
`ifdef SYNC_FIFO_FWFT_EN
      m_valid[k] = (mq[k].size() > 0);
      if (m_valid[k]) m_data[k] = mq[k][0];
`endif
    end
    @(posedge clk);
    #1;
    compare_all();
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0; din = '0;
    model_reset();
    @(posedge clk);
    #1 compare_all();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h33, 1'b0);
    step(1'b1, 1'b0, 8'h34, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 65 : 35;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
           8'($urandom), $urandom_range(0, 99) < 5);
    end

    async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    async_reset();
    step(1'b1, 1'b0, 8'h5C, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
